intel8080_clkgen: RTL

Clock-phase and control-synchronisation stage for the 8080 core, equivalent to the 8224 clock generator. It runs from the 50 MHz board clock and derives two-phase timing (phi1/phi2) as levels and single-cycle clock enables. It also synchronises the external reset and READY inputs to phi2 and produces the status strobe from the core's SYNC output. It sits directly upstream of the CPU core inside `intel8080_top`.

---
 rtl/intel8080_pkg.sv | 13 +
 rtl/intel8080_sync2.sv | 19 +
 rtl/intel8080_clkgen.sv | 86 ++++++++
 3 files changed

// File: rtl/intel8080_pkg.sv
// Shared 8080 timing constants: board-clock divider, phase lengths, reset hold.
package intel8080_pkg;
    localparam int I8080_CLK_DIV  = 9;
    localparam int I8080_PHI1_LEN = 2;
    localparam int I8080_PHI2_LEN = 5;
    localparam int I8080_RST_HOLD = 3;

    function automatic int ph_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    localparam int I8080_PH_W = ph_width(I8080_CLK_DIV);
endpackage

// File: rtl/intel8080_sync2.sv
// Two-flop synchroniser for a raw asynchronous level; clears to 0 on reset.
module intel8080_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta <= 1'b0;
            q_o  <= 1'b0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end
endmodule

// File: rtl/intel8080_clkgen.sv
// 8224-style clock generator: phi1/phi2 levels and strobes from the board clock,
// plus phi2-aligned reset/READY synchronisation and the status strobe.
module intel8080_clkgen
    import intel8080_pkg::*;
#(
    parameter int DIV      = I8080_CLK_DIV,
    parameter int PHI1_LEN = I8080_PHI1_LEN,
    parameter int PHI2_LEN = I8080_PHI2_LEN,
    parameter int RST_HOLD = I8080_RST_HOLD
) (
    input  logic clk50M_i,
    input  logic rst_i,
    input  logic resin_i,
    input  logic rdyin_i,
    input  logic sync_i,
    output logic phi1_o,
    output logic phi2_o,
    output logic phi1_stb_o,
    output logic phi2_stb_o,
    output logic reset_o,
    output logic ready_o,
    output logic ststb_no
);
    localparam int PH_W = ph_width(DIV);
    localparam int HW   = $clog2(RST_HOLD + 1);
    localparam logic [PH_W-1:0] LAST = PH_W'(DIV - 1);
    localparam logic [PH_W-1:0] P1   = PH_W'(PHI1_LEN);
    localparam logic [PH_W-1:0] P12  = PH_W'(PHI1_LEN + PHI2_LEN);

    if (PHI1_LEN < 1 || PHI2_LEN < 1 || PHI1_LEN + PHI2_LEN >= DIV) begin : g_bad_cfg
        $error("intel8080_clkgen: phase lengths leave no dead clock in the period");
    end

    logic [PH_W-1:0] ph, ph_nxt;
    logic [HW-1:0]   hold;
    logic            resin_s, rdy_s, res_pend;
    logic            at_p1, at_p2;

    intel8080_sync2 u_sync_res (.clk_i(clk50M_i), .rst_i(rst_i), .d_i(resin_i), .q_o(resin_s));
    intel8080_sync2 u_sync_rdy (.clk_i(clk50M_i), .rst_i(rst_i), .d_i(rdyin_i), .q_o(rdy_s));

    always_comb begin
        ph_nxt = (ph == LAST) ? '0 : ph + PH_W'(1);
        at_p1  = (ph_nxt == '0);
        at_p2  = (ph_nxt == P1);
    end

    // res_pend keeps a short resin pulse alive until the next phi2 edge consumes it.
    always_ff @(posedge clk50M_i or posedge rst_i) begin
        if (rst_i) begin
            ph         <= LAST;
            hold       <= HW'(RST_HOLD);
            res_pend   <= 1'b0;
            phi1_o     <= 1'b0;
            phi2_o     <= 1'b0;
            phi1_stb_o <= 1'b0;
            phi2_stb_o <= 1'b0;
            ready_o    <= 1'b0;
            reset_o    <= 1'b1;
            ststb_no   <= 1'b1;
        end else begin
            ph         <= ph_nxt;
            phi1_o     <= (ph_nxt < P1);
            phi2_o     <= (ph_nxt >= P1) && (ph_nxt < P12);
            phi1_stb_o <= at_p1;
            phi2_stb_o <= at_p2;
            if (at_p1) ststb_no <= ~sync_i;
            if (at_p2) begin
                ststb_no <= 1'b1;
                ready_o  <= rdy_s;
                res_pend <= 1'b0;
                if (resin_s || res_pend) begin
                    hold    <= HW'(RST_HOLD);
                    reset_o <= 1'b1;
                end else if (hold != '0) begin
                    hold    <= hold - HW'(1);
                    reset_o <= (hold > HW'(1));
                end else begin
                    reset_o <= 1'b0;
                end
            end else if (resin_s) begin
                res_pend <= 1'b1;
            end
        end
    end
endmodule
